// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: 16x oversampling, LSB-first frames of DATA_BITS data bits.
// The received word sits in a valid/ready holding register. The block flags framing errors
// and overruns.
// Optional feature: define UART_RX_PARITY_EN to add a PARITY state that checks one even-parity bit.
module uart_rx_deserializer #(
  parameter int unsigned CLK_FREQ  = 1_600_000,
  parameter int unsigned BAUD      = 100_000,
  parameter int unsigned DATA_BITS = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD * 16);
  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
  localparam logic [3:0] LastBit = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             sync_q;
  logic                   rx_s;
  logic [DivW-1:0]        div_q;
  logic [3:0]             samp_q;
  logic [3:0]             bit_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   data_q;
  logic                   valid_q;
  logic                   ferr_q;
  logic                   ovr_q;
  logic                   tick;
  logic                   mid;
  logic                   commit;
  logic                   bad;
`ifdef UART_RX_PARITY_EN
  logic                   par_err_q;
`endif

  assign rx_s        = sync_q[1];
  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign rx_busy     = (state_q != StIdle);
  assign frame_err   = ferr_q;
  assign overrun_err = ovr_q;

  // Next-state decode; commit/bad are single-cycle strobes at the stop-bit mid-sample.
  always_comb begin
    state_d = state_q;
    tick    = (div_q == DivLast);
    mid     = tick && (samp_q == 4'd7);
    commit  = 1'b0;
    bad     = 1'b0;
    unique case (state_q)
      StIdle:  if (!rx_s) state_d = StStart;
      StStart: if (mid) state_d = rx_s ? StIdle : StData;
      StData: begin
        if (mid && (bit_q == LastBit)) begin
`ifdef UART_RX_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: if (mid) state_d = StStop;
`endif
      StStop: begin
        if (mid) begin
          if (rx_s) begin
            state_d = StIdle;
`ifdef UART_RX_PARITY_EN
            commit  = !par_err_q;
            bad     = par_err_q;
`else
            commit  = 1'b1;
`endif
          end else begin
            state_d = StBreak;
            bad     = 1'b1;
          end
        end
      end
      StBreak: if (rx_s) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Line synchronizer, baud divider and per-bit sample counter (held clear while idle).
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      div_q  <= '0;
      samp_q <= '0;
    end else begin
      sync_q <= {sync_q[0], rx_serial};
      if (state_q == StIdle) begin
        div_q  <= '0;
        samp_q <= '0;
      end else if (tick) begin
        div_q  <= '0;
        samp_q <= samp_q + 4'd1;
      end else begin
        div_q  <= div_q + DivW'(1);
      end
    end
  end

  // Data shift register: each bit enters at the MSB so the LSB-first word ends up aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_q   <= '0;
      shift_q <= '0;
    end else if (mid && (state_q == StStart)) begin
      bit_q   <= '0;
    end else if (mid && (state_q == StData)) begin
      bit_q   <= bit_q + 4'd1;
      shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: data plus parity bit must contain an even number of ones.
  always_ff @(posedge clk) begin
    if (rst)                           par_err_q <= 1'b0;
    else if (mid && state_q == StParity) par_err_q <= ^{rx_s, shift_q};
  end
`endif

  // Holding register: a commit reloads when empty or drained in the same cycle, else overruns.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= bad;
      ovr_q  <= 1'b0;
      if (commit) begin
        if (!valid_q || rx_ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          ovr_q   <= 1'b1;
        end
      end else if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer at DIV=1 (16 clk per bit). Frames are built bit by bit from
// the wire format; a scoreboard queue holds the words the consumer should receive.
module tb_uart_rx_deserializer;

  localparam int DB = 9;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = 1 + DB + PB + 1;
  localparam int LatNom = (1 + DB + PB) * 16 + 8 + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_serial;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          rx_busy;
  logic          frame_err;
  logic          overrun_err;

  int n_tests = 0;
  int n_fail  = 0;
  int fe_cnt  = 0;
  int ov_cnt  = 0;
  int fe_exp  = 0;
  int ov_exp  = 0;
  logic [DB-1:0] got_q[$];
  logic [DB-1:0] exp_q[$];

  uart_rx_deserializer #(
    .CLK_FREQ (1_600_000),
    .BAUD     (100_000),
    .DATA_BITS(DB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_serial  (rx_serial),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Consumer-side monitor: record accepted words and pulses, check hold stability.
  logic          prev_hold = 1'b0;
  logic [DB-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && rx_valid) chk("hold_stable", 32'(rx_data), 32'(prev_data));
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) fe_cnt++;
      if (overrun_err) ov_cnt++;
      if (frame_err || overrun_err) chk("err_exclusive", 32'(frame_err && overrun_err), 32'd0);
      prev_hold = rx_valid && !rx_ready;
      prev_data = rx_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one frame; optional one-cycle rx_ready pulse at cycle 'pulse'; stop early at max_cyc.
  task automatic send_frame(input logic [DB-1:0] w, input logic stop_b, input logic par_ok,
                            input int pulse, input int max_cyc, output int rise);
    logic bits [NB];
    logic pv;
    bits[0] = 1'b0;
    for (int i = 0; i < DB; i++) bits[1+i] = w[i];
    if (PB == 1) bits[1+DB] = (^w) ^ !par_ok;
    bits[NB-1] = stop_b;
    rise = -1;
    for (int c = 0; c < NB * 16 && c < max_cyc; c++) begin
      rx_serial = bits[c/16];
      if (pulse >= 0 && c == pulse) rx_ready = 1'b1;
      else if (pulse >= 0 && c == pulse + 1) rx_ready = 1'b0;
      pv = rx_valid;
      tick(1);
      if (rise < 0 && rx_valid && !pv) rise = c + 1;
    end
  endtask

  task automatic check_q(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_word"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
    chk({tag, "_ferr"}, 32'(fe_cnt), 32'(fe_exp));
    chk({tag, "_ovr"}, 32'(ov_cnt), 32'(ov_exp));
  endtask

  initial begin
    int lat;
    int r;
    logic [DB-1:0] w;
    logic [DB-1:0] wa;
    logic [DB-1:0] wb;
    logic stop_b;

    rst = 1'b1;
    rx_serial = 1'b1;
    rx_ready = 1'b1;
    tick(3);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_busy", 32'(rx_busy), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun_err), 32'd0);
    rst = 1'b0;
    tick(5);

    // Basic frame, consumer always ready.
    send_frame(9'h1A5, 1'b1, 1'b1, -1, 1 << 30, lat);
    exp_q.push_back(9'h1A5);
    tick(10);
    chk("latency_window", 32'(lat >= LatNom - 2 && lat <= LatNom + 2), 32'd1);
    check_q("t1");

    // Short low glitch on the idle line.
    rx_serial = 1'b0;
    tick(4);
    rx_serial = 1'b1;
    tick(30);
    chk("glitch_busy", 32'(rx_busy), 32'd0);
    chk("glitch_valid", 32'(rx_valid), 32'd0);
    check_q("t2");

    // Stop bit low followed by a long low (break).
    send_frame(9'h0FF, 1'b0, 1'b1, -1, 1 << 30, r);
    fe_exp++;
    tick(40);
    chk("break_busy", 32'(rx_busy), 32'd1);
    chk("break_valid", 32'(rx_valid), 32'd0);
    rx_serial = 1'b1;
    tick(4);
    chk("break_idle", 32'(rx_busy), 32'd0);
    check_q("t3");

    // Random frames with occasional bad stop bits.
    for (int i = 0; i < 6; i++) begin
      w = DB'($urandom);
      stop_b = ($urandom_range(0, 3) != 0);
      send_frame(w, stop_b, 1'b1, -1, 1 << 30, r);
      if (stop_b) begin
        exp_q.push_back(w);
      end else begin
        fe_exp++;
        tick($urandom_range(20, 40));
        rx_serial = 1'b1;
        tick(20);
      end
      tick($urandom_range(0, 10));
    end
    tick(5);
    check_q("rand");

    // Overrun: consumer stalled across two frames.
    rx_ready = 1'b0;
    send_frame(9'h001, 1'b1, 1'b1, -1, 1 << 30, r);
    send_frame(9'h1FE, 1'b1, 1'b1, -1, 1 << 30, r);
    ov_exp++;
    tick(5);
    chk("ovr_valid", 32'(rx_valid), 32'd1);
    chk("ovr_data", 32'(rx_data), 32'h001);
    rx_ready = 1'b1;
    tick(1);
    exp_q.push_back(9'h001);
    chk("ovr_drain", 32'(rx_valid), 32'd0);
    check_q("t4");

    // Ready pulsed exactly on the second commit cycle: accept-and-reload, no overrun.
    rx_ready = 1'b0;
    wa = DB'($urandom);
    wb = DB'($urandom);
    send_frame(wa, 1'b1, 1'b1, -1, 1 << 30, r);
    send_frame(wb, 1'b1, 1'b1, lat - 1, 1 << 30, r);
    exp_q.push_back(wa);
    tick(5);
    chk("reload_valid", 32'(rx_valid), 32'd1);
    chk("reload_data", 32'(rx_data), 32'(wb));
    rx_ready = 1'b1;
    tick(2);
    exp_q.push_back(wb);
    check_q("t5");

    // Reset mid-frame with a word already held; neither may be delivered.
    rx_ready = 1'b0;
    send_frame(DB'($urandom), 1'b1, 1'b1, -1, 1 << 30, r);
    send_frame(DB'($urandom), 1'b1, 1'b1, -1, 16 + 4 * 16 + 8, r);
    rst = 1'b1;
    rx_serial = 1'b1;
    tick(1);
    chk("mrst_valid", 32'(rx_valid), 32'd0);
    chk("mrst_data", 32'(rx_data), 32'd0);
    chk("mrst_busy", 32'(rx_busy), 32'd0);
    chk("mrst_ferr", 32'(frame_err), 32'd0);
    tick(3);
    rst = 1'b0;
    rx_ready = 1'b1;
    tick(20);
    send_frame(9'h155, 1'b1, 1'b1, -1, 1 << 30, r);
    exp_q.push_back(9'h155);
    tick(5);
    check_q("t6");

`ifdef UART_RX_PARITY_EN
    // Parity error with a good stop bit: frame dropped, frame_err pulses.
    send_frame(9'h003, 1'b1, 1'b0, -1, 1 << 30, r);
    fe_exp++;
    tick(5);
    chk("par_valid", 32'(rx_valid), 32'd0);
    check_q("par");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
